// File: rtl/sdram_cmd_monitor_if.sv
// SDRAM command-pin bundle as seen between the arbiter mux and the pads.
// master: the side driving the pins; slave: passive observers such as the monitor.
interface sdram_cmd_monitor_if;
  logic [1:0]  CS_N;
  logic        CKE;
  logic        RAS_N;
  logic        CAS_N;
  logic        WE_N;
  logic [1:0]  BA;
  logic [11:0] SA;

  modport master (output CS_N, CKE, RAS_N, CAS_N, WE_N, BA, SA);
  modport slave  (input  CS_N, CKE, RAS_N, CAS_N, WE_N, BA, SA);
endinterface

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command monitor: decodes the command pins, tracks mode register,
// open rows and per-bank timing, regenerates read-data-valid / write-beat strobes
// and flags protocol violations.
// Optional feature macro: SDRAM_CMD_MONITOR_COUNT_EN (saturating command counter).
module sdram_cmd_monitor #(
  parameter int unsigned TRCD       = 2,
  parameter int unsigned TRP        = 2,
  parameter int unsigned PAGE_BEATS = 256
) (
  input  logic               clk,
  input  logic               Reset_N,
  sdram_cmd_monitor_if.slave cmd,
  output logic [11:0]        ModeReg,
  output logic               ModeValid,
  output logic [3:0]         BankOpen,
  output logic [47:0]        OpenRows,
  output logic               RdDataValid,
  output logic               WrBeat,
  output logic               Violation,
  output logic [2:0]         ViolationCode,
  output logic [15:0]        CmdCount
);

  localparam int unsigned TMAX   = (TRCD > TRP) ? TRCD : TRP;
  localparam int unsigned TMR_W  = (TMAX == 0) ? 1 : $clog2(TMAX + 1);
  localparam int unsigned BEAT_W = $clog2(PAGE_BEATS + 1);

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  // Registered state
  logic [TMR_W-1:0]  timer_q [4];
  logic [11:0]       row_q   [4];
  logic [1:0]        rd_wait_q;
  logic [BEAT_W-1:0] rd_left_q;
  logic [BEAT_W-1:0] rd_bl_q;
  logic [1:0]        rd_bank_q;
  logic [BEAT_W-1:0] wr_left_q;

  // Next-state values
  logic [TMR_W-1:0]  timer_d [4];
  logic [11:0]       row_d   [4];
  logic [1:0]        rd_wait_d;
  logic [BEAT_W-1:0] rd_left_d;
  logic [BEAT_W-1:0] rd_bl_d;
  logic [1:0]        rd_bank_d;
  logic [BEAT_W-1:0] wr_left_d;
  logic [11:0]       mode_reg_d;
  logic              mode_valid_d;
  logic [3:0]        bank_open_d;
  logic              rd_dv_d;
  logic              wr_beat_d;
  logic              viol_d;
  logic [2:0]        viol_code_d;

  logic              cmd_en_c;
  cmd_e              cmd_c;
  logic [1:0]        cl_c;
  logic [BEAT_W-1:0] bl_c;

  assign cmd_en_c = cmd.CKE && (cmd.CS_N != 2'b11);
  assign cmd_c    = cmd_e'({cmd.RAS_N, cmd.CAS_N, cmd.WE_N});
  assign OpenRows = {row_q[3], row_q[2], row_q[1], row_q[0]};

  // CAS latency and burst length implied by the current mode register
  always_comb begin
    cl_c = (ModeReg[6:4] == 3'd2) ? 2'd2 : 2'd3;
    case (ModeReg[2:0])
      3'b000:  bl_c = BEAT_W'(1);
      3'b001:  bl_c = BEAT_W'(2);
      3'b010:  bl_c = BEAT_W'(4);
      3'b011:  bl_c = BEAT_W'(8);
      3'b111:  bl_c = BEAT_W'(PAGE_BEATS);
      default: bl_c = BEAT_W'(1);
    endcase
  end

  // Next-state: timers, burst progress, command effects and violation checks
  always_comb begin
    mode_reg_d   = ModeReg;
    mode_valid_d = ModeValid;
    bank_open_d  = BankOpen;
    timer_d      = timer_q;
    row_d        = row_q;
    rd_wait_d    = rd_wait_q;
    rd_left_d    = rd_left_q;
    rd_bl_d      = rd_bl_q;
    rd_bank_d    = rd_bank_q;
    wr_left_d    = wr_left_q;
    rd_dv_d      = 1'b0;
    wr_beat_d    = 1'b0;
    viol_d       = 1'b0;
    viol_code_d  = ViolationCode;

    // With CKE low everything freezes and the strobes drop
    if (cmd.CKE) begin
      for (int b = 0; b < 4; b++) begin
        if (timer_q[b] != '0) timer_d[b] = timer_q[b] - TMR_W'(1);
      end

      // A pending read start emerges after CL enabled cycles
      if (rd_wait_q != 2'd0) begin
        rd_wait_d = rd_wait_q - 2'd1;
        if (rd_wait_q == 2'd1) begin
          rd_dv_d   = 1'b1;
          rd_left_d = rd_bl_q - BEAT_W'(1);
        end
      end else if (rd_left_q != '0) begin
        rd_dv_d   = 1'b1;
        rd_left_d = rd_left_q - BEAT_W'(1);
      end

      if (wr_left_q != '0) begin
        wr_beat_d = 1'b1;
        wr_left_d = wr_left_q - BEAT_W'(1);
      end

      if (cmd_en_c) begin
        case (cmd_c)
          CMD_LMR: begin
            mode_reg_d   = cmd.SA;
            mode_valid_d = 1'b1;
            if (|BankOpen) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd6;
            end
          end
          CMD_REF: begin
            if (|BankOpen) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd6;
            end
          end
          CMD_PRE: begin
            for (int b = 0; b < 4; b++) begin
              if (cmd.SA[10] || (cmd.BA == 2'(b))) begin
                bank_open_d[b] = 1'b0;
                timer_d[b]     = TMR_W'(TRP);
              end
            end
            if (cmd.SA[10] || (cmd.BA == rd_bank_q)) begin
              rd_wait_d = 2'd0;
              rd_left_d = '0;
              rd_dv_d   = 1'b0;
            end
            wr_left_d = '0;
            wr_beat_d = 1'b0;
          end
          CMD_ACT: begin
            if (BankOpen[cmd.BA]) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd4;
            end else if (timer_q[cmd.BA] != '0) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd5;
            end
            bank_open_d[cmd.BA] = 1'b1;
            row_d[cmd.BA]       = cmd.SA;
            timer_d[cmd.BA]     = TMR_W'(TRCD);
          end
          CMD_RD, CMD_WR: begin
            if (!ModeValid) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd1;
            end else if (!BankOpen[cmd.BA]) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd2;
            end else if (timer_q[cmd.BA] != '0) begin
              viol_d      = 1'b1;
              viol_code_d = 3'd3;
            end
            // Any access ends both bursts; the new one is then scheduled
            rd_wait_d = 2'd0;
            rd_left_d = '0;
            rd_dv_d   = 1'b0;
            wr_left_d = '0;
            wr_beat_d = 1'b0;
            if (cmd_c == CMD_RD) begin
              rd_wait_d = cl_c;
              rd_bl_d   = bl_c;
              rd_bank_d = cmd.BA;
            end else begin
              wr_beat_d = 1'b1;
              wr_left_d = bl_c - BEAT_W'(1);
            end
          end
          CMD_BST: begin
            rd_wait_d = 2'd0;
            rd_left_d = '0;
            rd_dv_d   = 1'b0;
            wr_left_d = '0;
            wr_beat_d = 1'b0;
          end
          CMD_NOP: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      ModeReg       <= '0;
      ModeValid     <= 1'b0;
      BankOpen      <= '0;
      RdDataValid   <= 1'b0;
      WrBeat        <= 1'b0;
      Violation     <= 1'b0;
      ViolationCode <= '0;
      timer_q       <= '{default: '0};
      row_q         <= '{default: '0};
      rd_wait_q     <= '0;
      rd_left_q     <= '0;
      rd_bl_q       <= '0;
      rd_bank_q     <= '0;
      wr_left_q     <= '0;
    end else begin
      ModeReg       <= mode_reg_d;
      ModeValid     <= mode_valid_d;
      BankOpen      <= bank_open_d;
      RdDataValid   <= rd_dv_d;
      WrBeat        <= wr_beat_d;
      Violation     <= viol_d;
      ViolationCode <= viol_code_d;
      timer_q       <= timer_d;
      row_q         <= row_d;
      rd_wait_q     <= rd_wait_d;
      rd_left_q     <= rd_left_d;
      rd_bl_q       <= rd_bl_d;
      rd_bank_q     <= rd_bank_d;
      wr_left_q     <= wr_left_d;
    end
  end

`ifdef SDRAM_CMD_MONITOR_COUNT_EN
  // Saturating count of decoded non-NOP commands
  always_ff @(posedge clk) begin
    if (!Reset_N) begin
      CmdCount <= '0;
    end else if (cmd_en_c && (cmd_c != CMD_NOP) && (CmdCount != 16'hFFFF)) begin
      CmdCount <= CmdCount + 16'd1;
    end
  end
`else
  assign CmdCount = '0;
`endif

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Self-checking bench for sdram_cmd_monitor: directed test-plan steps followed by
// randomized command traffic, all compared against a window-based reference model.
module tb_sdram_cmd_monitor;

  localparam int unsigned TRCD       = 2;
  localparam int unsigned TRP        = 2;
  localparam int unsigned PAGE_BEATS = 256;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        Reset_N;
  logic [11:0] ModeReg;
  logic        ModeValid;
  logic [3:0]  BankOpen;
  logic [47:0] OpenRows;
  logic        RdDataValid;
  logic        WrBeat;
  logic        Violation;
  logic [2:0]  ViolationCode;
  logic [15:0] CmdCount;

  sdram_cmd_monitor_if itf ();

  sdram_cmd_monitor #(
    .TRCD(TRCD), .TRP(TRP), .PAGE_BEATS(PAGE_BEATS)
  ) dut (
    .clk(clk), .Reset_N(Reset_N), .cmd(itf),
    .ModeReg(ModeReg), .ModeValid(ModeValid), .BankOpen(BankOpen),
    .OpenRows(OpenRows), .RdDataValid(RdDataValid), .WrBeat(WrBeat),
    .Violation(Violation), .ViolationCode(ViolationCode), .CmdCount(CmdCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bursts are windows of enabled-edge indices, bank timing is
  // the enabled-edge index from which an access/activate becomes legal.
  int          ecnt = 0;
  logic [11:0] m_mode;
  logic        m_mv;
  logic [3:0]  m_open;
  logic [11:0] m_row [4];
  int          m_ready [4];
  int          rd_first, rd_last, wr_first, wr_last;
  logic [1:0]  rd_bank;
  logic        m_viol, m_dv, m_wb;
  logic [2:0]  m_code;
  logic [15:0] m_cnt;

  function automatic int mcl(input logic [11:0] m);
    return (m[6:4] == 3'd2) ? 2 : 3;
  endfunction

  function automatic int mbl(input logic [11:0] m);
    case (m[2:0])
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      3'b011:  return 8;
      3'b111:  return PAGE_BEATS;
      default: return 1;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = '0; m_mv = 1'b0; m_open = '0;
    for (int b = 0; b < 4; b++) begin m_row[b] = '0; m_ready[b] = 0; end
    rd_first = 0; rd_last = -1; wr_first = 0; wr_last = -1;
    rd_bank = '0; m_viol = 1'b0; m_dv = 1'b0; m_wb = 1'b0; m_code = '0; m_cnt = '0;
  endtask

  task automatic model_edge(input logic cke, input logic [1:0] cs, input logic [2:0] c,
                            input logic [1:0] ba, input logic [11:0] sa);
    int e;
    int code;
    if (!Reset_N) begin
      model_reset();
      return;
    end
    m_viol = 1'b0;
    if (!cke) begin
      m_dv = 1'b0;
      m_wb = 1'b0;
      return;
    end
    ecnt++;
    e = ecnt;
    if (cs != 2'b11) begin
      code = 0;
      if (c != C_NOP && m_cnt != 16'hFFFF) m_cnt++;
      case (c)
        C_RD, C_WR: begin
          if (!m_mv) code = 1;
          else if (!m_open[ba]) code = 2;
          else if (e < m_ready[ba]) code = 3;
          if (rd_last > e - 1) rd_last = e - 1;
          if (wr_last > e - 1) wr_last = e - 1;
          if (c == C_RD) begin
            rd_first = e + mcl(m_mode);
            rd_last  = rd_first + mbl(m_mode) - 1;
            rd_bank  = ba;
          end else begin
            wr_first = e;
            wr_last  = e + mbl(m_mode) - 1;
          end
        end
        C_ACT: begin
          if (m_open[ba]) code = 4;
          else if (e < m_ready[ba]) code = 5;
          m_open[ba] = 1'b1;
          m_row[ba] = sa;
          m_ready[ba] = e + TRCD + 1;
        end
        C_PRE: begin
          for (int b = 0; b < 4; b++) begin
            if (sa[10] || ba == 2'(b)) begin
              m_open[b] = 1'b0;
              m_ready[b] = e + TRP + 1;
            end
          end
          if ((sa[10] || ba == rd_bank) && rd_last > e - 1) rd_last = e - 1;
          if (wr_last > e - 1) wr_last = e - 1;
        end
        C_REF: if (|m_open) code = 6;
        C_LMR: begin
          if (|m_open) code = 6;
          m_mode = sa;
          m_mv = 1'b1;
        end
        C_BST: begin
          if (rd_last > e - 1) rd_last = e - 1;
          if (wr_last > e - 1) wr_last = e - 1;
        end
        default: ;
      endcase
      if (code != 0) begin
        m_viol = 1'b1;
        m_code = 3'(code);
      end
    end
    m_dv = (e >= rd_first) && (e <= rd_last);
    m_wb = (e >= wr_first) && (e <= wr_last);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ModeReg", 64'(ModeReg), 64'(m_mode));
    chk("ModeValid", 64'(ModeValid), 64'(m_mv));
    chk("BankOpen", 64'(BankOpen), 64'(m_open));
    chk("OpenRows", 64'(OpenRows), 64'({m_row[3], m_row[2], m_row[1], m_row[0]}));
    chk("RdDataValid", 64'(RdDataValid), 64'(m_dv));
    chk("WrBeat", 64'(WrBeat), 64'(m_wb));
    chk("Violation", 64'(Violation), 64'(m_viol));
    chk("ViolationCode", 64'(ViolationCode), 64'(m_code));
`ifdef SDRAM_CMD_MONITOR_COUNT_EN
    chk("CmdCount", 64'(CmdCount), 64'(m_cnt));
`else
    chk("CmdCount", 64'(CmdCount), 64'd0);
`endif
  endtask

  task automatic cyc(input logic cke, input logic [1:0] cs, input logic [2:0] c,
                     input logic [1:0] ba, input logic [11:0] sa);
    itf.CKE = cke;
    itf.CS_N = cs;
    {itf.RAS_N, itf.CAS_N, itf.WE_N} = c;
    itf.BA = ba;
    itf.SA = sa;
    @(posedge clk);
    model_edge(cke, cs, c, ba, sa);
    #1;
    check_all();
  endtask

  task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] sa);
    cyc(1'b1, 2'b10, c, ba, sa);
  endtask

  task automatic nop();
    cyc(1'b1, 2'b10, C_NOP, 2'd0, 12'h000);
  endtask

  task automatic do_reset();
    Reset_N = 1'b0;
    nop();
    Reset_N = 1'b1;
  endtask

  int first, beats, wbeats;
  logic [11:0] lmr_tab [10];

  initial begin
    Reset_N = 1'b0;
    model_reset();
    cyc(1'b1, 2'b11, C_NOP, 2'd0, 12'h000);
    cyc(1'b1, 2'b11, C_NOP, 2'd0, 12'h000);
    chk("reset_dv", 64'(RdDataValid), 64'd0);
    chk("reset_modevalid", 64'(ModeValid), 64'd0);
    Reset_N = 1'b1;

    // CL3/BL1 single read
    cmd(C_LMR, 2'd0, 12'h030);
    cmd(C_ACT, 2'd0, 12'h123);
    nop(); nop();
    cmd(C_RD, 2'd0, 12'h000);
    chk("t1_modevalid", 64'(ModeValid), 64'd1);
    chk("t1_row0", 64'(OpenRows[11:0]), 64'h123);
    chk("t1_noviol", 64'(Violation), 64'd0);
    first = -1; beats = 0;
    for (int i = 1; i <= 6; i++) begin
      nop();
      if (RdDataValid) begin beats++; if (first < 0) first = i; end
    end
    chk("t1_first_beat", 64'(first), 64'd3);
    chk("t1_beats", 64'(beats), 64'd1);

    // CL2/BL4: write truncated by a read
    do_reset();
    cmd(C_LMR, 2'd0, 12'h022);
    cmd(C_ACT, 2'd1, 12'h055);
    nop(); nop();
    cmd(C_WR, 2'd1, 12'h000);
    wbeats = int'(WrBeat);
    cmd(C_RD, 2'd1, 12'h000);
    wbeats += int'(WrBeat);
    first = -1; beats = 0;
    for (int i = 1; i <= 8; i++) begin
      nop();
      wbeats += int'(WrBeat);
      if (RdDataValid) begin beats++; if (first < 0) first = i; end
    end
    chk("t2_wr_beats", 64'(wbeats), 64'd1);
    chk("t2_first_beat", 64'(first), 64'd2);
    chk("t2_rd_beats", 64'(beats), 64'd4);

    // Read before any LOAD MODE
    do_reset();
    cmd(C_RD, 2'd0, 12'h000);
    chk("t3_viol", 64'(Violation), 64'd1);
    chk("t3_code", 64'(ViolationCode), 64'd1);

    // tRCD violation then double ACTIVE
    cmd(C_LMR, 2'd0, 12'h022);
    cmd(C_ACT, 2'd2, 12'h0AA);
    cmd(C_RD, 2'd2, 12'h000);
    chk("t4_viol_trcd", 64'(Violation), 64'd1);
    chk("t4_code_trcd", 64'(ViolationCode), 64'd3);
    cmd(C_ACT, 2'd2, 12'h0BB);
    chk("t4_code_open", 64'(ViolationCode), 64'd4);
    nop();
    chk("t4_pulse_end", 64'(Violation), 64'd0);
    chk("t4_code_hold", 64'(ViolationCode), 64'd4);

    // Full-page read terminated after 10 beats
    do_reset();
    cmd(C_LMR, 2'd0, 12'h037);
    cmd(C_ACT, 2'd0, 12'h010);
    nop(); nop();
    cmd(C_RD, 2'd0, 12'h000);
    beats = 0;
    for (int i = 0; i < 40 && beats < 10; i++) begin
      nop();
      if (RdDataValid) beats++;
    end
    cmd(C_BST, 2'd0, 12'h000);
    if (RdDataValid) beats++;
    for (int i = 0; i < 10; i++) begin
      nop();
      if (RdDataValid) beats++;
    end
    chk("t5_page_beats", 64'(beats), 64'd10);

    // BL8 read with a 2-cycle CKE gap, then reset mid-burst
    do_reset();
    cmd(C_LMR, 2'd0, 12'h033);
    cmd(C_ACT, 2'd0, 12'h020);
    nop(); nop();
    cmd(C_RD, 2'd0, 12'h000);
    beats = 0;
    for (int i = 0; i < 4; i++) begin nop(); if (RdDataValid) beats++; end
    cyc(1'b0, 2'b10, C_NOP, 2'd0, 12'h000);
    chk("t6_gap1", 64'(RdDataValid), 64'd0);
    cyc(1'b0, 2'b10, C_NOP, 2'd0, 12'h000);
    chk("t6_gap2", 64'(RdDataValid), 64'd0);
    for (int i = 0; i < 12; i++) begin nop(); if (RdDataValid) beats++; end
    chk("t6_total_beats", 64'(beats), 64'd8);
    cmd(C_RD, 2'd0, 12'h000);
    nop(); nop(); nop();
    chk("t6_burst_live", 64'(RdDataValid), 64'd1);
    Reset_N = 1'b0;
    nop();
    Reset_N = 1'b1;
    chk("t6_rst_dv", 64'(RdDataValid), 64'd0);
    chk("t6_rst_mv", 64'(ModeValid), 64'd0);
    chk("t6_rst_open", 64'(BankOpen), 64'd0);
    chk("t6_rst_rows", 64'(OpenRows), 64'd0);
    for (int i = 0; i < 6; i++) nop();

    // Randomized traffic
    lmr_tab[0] = 12'h020; lmr_tab[1] = 12'h021; lmr_tab[2] = 12'h022;
    lmr_tab[3] = 12'h023; lmr_tab[4] = 12'h030; lmr_tab[5] = 12'h031;
    lmr_tab[6] = 12'h032; lmr_tab[7] = 12'h033; lmr_tab[8] = 12'h037;
    lmr_tab[9] = 12'h045;
    for (int i = 0; i < 4000; i++) begin
      logic        cke;
      logic [1:0]  cs;
      logic [2:0]  c;
      logic [11:0] sa;
      int          r;
      Reset_N = ($urandom_range(0, 599) != 0);
      cke = ($urandom_range(0, 9) != 0);
      cs = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r = int'($urandom_range(0, 99));
      if (r < 35) c = C_NOP;
      else if (r < 50) c = C_ACT;
      else if (r < 63) c = C_RD;
      else if (r < 73) c = C_WR;
      else if (r < 83) c = C_PRE;
      else if (r < 88) c = C_BST;
      else if (r < 93) c = C_REF;
      else c = C_LMR;
      sa = 12'($urandom);
      if (c == C_LMR) sa = lmr_tab[$urandom_range(0, 9)];
      cyc(cke, cs, c, 2'($urandom_range(0, 3)), sa);
    end
    Reset_N = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
